// File: rtl/count_sequencer_pkg.sv
// Shared widths, state encodings and latched-configuration type for the count sequencer.
package count_sequencer_pkg;

   localparam int unsigned WIDTH   = 4;
   localparam int unsigned SWEEP_W = 8;

   // 3-bit state encodings, visible to the bench for state-aware checks
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_PRIME = 3'd2,
      ST_UP    = 3'd3,
      ST_DOWN  = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   // Sweep configuration captured on an accepted start
   typedef struct packed {
      logic [WIDTH-1:0]   lo;
      logic [WIDTH-1:0]   hi;
      logic [SWEEP_W-1:0] n_sweeps;
   } cfg_t;

   // A sweep range is usable only when the lower bound does not exceed the upper
   function automatic logic cfg_valid(cfg_t c);
      return c.lo <= c.hi;
   endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Host/counter-side signal bundle of the count sequencer.
interface count_sequencer_if;
   import count_sequencer_pkg::*;

   logic               start;
   logic               stop;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [SWEEP_W-1:0] n_sweeps;
   logic [WIDTH-1:0]   count;
   logic               ctr_rst;
   logic               en;
   logic               dn;
   logic               busy;
   logic               done;
   logic               err;
   logic [SWEEP_W-1:0] sweep_idx;

   // Sequencer side
   modport slave (
      input  start, stop, lo, hi, n_sweeps, count,
      output ctr_rst, en, dn, busy, done, err, sweep_idx
   );

   // Host plus counter side
   modport master (
      output start, stop, lo, hi, n_sweeps, count,
      input  ctr_rst, en, dn, busy, done, err, sweep_idx
   );

endinterface

// File: rtl/count_sequencer.sv
// Drives an external up/down counter through primed ping-pong sweeps between lo and hi.
module count_sequencer
   import count_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   count_sequencer_if.slave  bus
);

   state_t             state;
   cfg_t               cfg;
   cfg_t               cfg_in;
   logic [SWEEP_W-1:0] sweep_next;
   logic               en_c;

   assign cfg_in     = '{lo: bus.lo, hi: bus.hi, n_sweeps: bus.n_sweeps};
   assign sweep_next = SWEEP_W'(bus.sweep_idx + 1'b1);

   // Counter enable straight from state and count so the counter lands exactly on its target
   always_comb begin
      en_c = 1'b0;
      case (state)
         ST_PRIME: en_c = (bus.count != cfg.lo);
         ST_UP:    en_c = (bus.count != cfg.hi);
         ST_DOWN:  en_c = (bus.count != cfg.lo);
         default:  en_c = 1'b0;
      endcase
      if (bus.stop) en_c = 1'b0;
   end

   assign bus.en = en_c;

   // Sweep FSM with registered control and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         cfg           <= '0;
         bus.ctr_rst   <= 1'b0;
         bus.dn        <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.sweep_idx <= '0;
      end else begin
         bus.ctr_rst <= 1'b0;
         bus.done    <= 1'b0;
         bus.err     <= 1'b0;
         if ((state != ST_IDLE) && bus.stop) begin
            // abort: back to idle, no done pulse, sweep_idx keeps its value
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            bus.dn   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start) begin
                     if (!cfg_valid(cfg_in)) begin
                        bus.err <= 1'b1;
                     end else if (!bus.stop) begin
                        cfg           <= cfg_in;
                        bus.sweep_idx <= '0;
                        bus.ctr_rst   <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.dn        <= 1'b0;
                        state         <= ST_CLEAR;
                     end
                  end
               end
               ST_CLEAR: state <= ST_PRIME;
               ST_PRIME: begin
                  if (bus.count == cfg.lo) begin
                     if (cfg.n_sweeps == '0) begin
                        state    <= ST_FIN;
                        bus.done <= 1'b1;
                     end else begin
                        state <= ST_UP;
                     end
                  end
               end
               ST_UP: begin
                  if (bus.count == cfg.hi) begin
                     state  <= ST_DOWN;
                     bus.dn <= 1'b1;
                  end
               end
               ST_DOWN: begin
                  if (bus.count == cfg.lo) begin
                     bus.sweep_idx <= sweep_next;
                     bus.dn        <= 1'b0;
                     if (sweep_next == cfg.n_sweeps) begin
                        state    <= ST_FIN;
                        bus.done <= 1'b1;
                     end else begin
                        state <= ST_UP;
                     end
                  end
               end
               ST_FIN: begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
               end
               default: begin
                  state    <= ST_IDLE;
                  bus.busy <= 1'b0;
                  bus.dn   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
